// File: rtl/demux1x2_stream.sv
// demux1x2_stream
//   Routes a valid/ready input stream to one of two output streams. Each
//   output channel has its own 2-entry FIFO, so a stall on one output does
//   not block beats headed for the other.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   in, sel, in_valid        input beat; sel=0 -> out1, sel=1 -> out2
//   in_ready                 beat accepted this cycle (selected queue not full)
//   outN, outN_valid         head of channel N queue (0 while empty)
//   outN_ready               consumer takes the head of channel N
//   outN_count               channel N occupancy, 0..2
//   outN_xfers               completed pops on channel N (wrapping)

// demux1x2_stream_fifo
//   One output channel: 2-entry FIFO with occupancy and a pop counter.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   push, wr_data            write wr_data at the tail (caller ensures not full)
//   rd_ready                 consumer takes the head when non-empty
//   rd_data, rd_valid        head entry (0 while empty), non-empty flag
//   count                    occupancy, 0..2
//   xfers                    completed pops (wrapping)
module demux1x2_stream_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic [1:0]       count,
    output logic [CNT_W-1:0] xfers
);

    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] xfers_q, xfers_d;
    logic             pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        xfers_d  = xfers_q;

        rd_valid = (cnt_q != 2'd0);
        pop      = rd_valid && rd_ready;

        if (push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
            xfers_d  = xfers_q + CNT_W'(1);
        end

        // Push and pop together leave occupancy unchanged.
        if (push && !pop) begin
            cnt_d = cnt_q + 2'd1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 2'd1;
        end

        rd_data = rd_valid ? mem_q[rd_ptr_q] : '0;
        count   = cnt_q;
        xfers   = xfers_q;
    end

    // Storage is not reset; the head is masked by rd_valid instead.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= '0;
            xfers_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            xfers_q  <= xfers_d;
        end
    end

endmodule

module demux1x2_stream #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic             sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out1,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [1:0]       out1_count,
    output logic [CNT_W-1:0] out1_xfers,
    output logic [WIDTH-1:0] out2,
    output logic             out2_valid,
    input  logic             out2_ready,
    output logic [1:0]       out2_count,
    output logic [CNT_W-1:0] out2_xfers
);

    logic push1;
    logic push2;

    // Readiness looks only at the selected queue's registered count, so a
    // same-cycle pop never makes room for the incoming beat.
    always_comb begin
        in_ready = sel ? (out2_count != 2'd2) : (out1_count != 2'd2);
        push1    = in_valid && in_ready && !sel;
        push2    = in_valid && in_ready &&  sel;
    end

    demux1x2_stream_fifo #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_ch1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push1),
        .wr_data  (in),
        .rd_ready (out1_ready),
        .rd_data  (out1),
        .rd_valid (out1_valid),
        .count    (out1_count),
        .xfers    (out1_xfers)
    );

    demux1x2_stream_fifo #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_ch2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push2),
        .wr_data  (in),
        .rd_ready (out2_ready),
        .rd_data  (out2),
        .rd_valid (out2_valid),
        .count    (out2_count),
        .xfers    (out2_xfers)
    );

endmodule

// File: doc/demux1x2_stream.md
DEMUX1X2_STREAM -- requirements
Module: demux1x2_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of all data ports.
REQ-002 SHALL have parameter CNT_W, default 16, width of per-output transfer counters.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in  input  WIDTH  input data word.
REQ-006 sel  input  1  destination: 0 -> out1, 1 -> out2; sampled with in.
REQ-007 in_valid  input  1  in/sel hold a valid beat.
REQ-008 in_ready  output  1  block accepts the beat this cycle.
REQ-009 out1 / out2  output  WIDTH  head data of channel 1 / 2 queue.
REQ-010 out1_valid / out2_valid  output  1  channel queue non-empty.
REQ-011 out1_ready / out2_ready  input  1  consumer takes head this cycle.
REQ-012 out1_count / out2_count  output  2  channel queue occupancy, 0..2.
REQ-013 out1_xfers / out2_xfers  output  CNT_W  completed output transfers per channel.

Function
REQ-014 Each channel SHALL own an independent 2-entry FIFO (registered storage, wr/rd pointers, occupancy count).
REQ-015 Accept = in_valid && in_ready; on accept, in SHALL be written to FIFO selected by sel at that edge.
REQ-016 in_ready SHALL be 1 iff FIFO selected by current sel has count < 2; same-cycle pop SHALL NOT free space for push (no pass-through).
REQ-017 in_ready SHALL be combinational from sel and registered counts only; no dependence on in_valid or outN_ready.
REQ-018 Latency: beat accepted at edge N SHALL appear on outN with outN_valid=1 from edge N onward (visible cycle N+1); no combinational in->out path.
REQ-019 outN SHALL equal FIFO head entry; outN SHALL hold stable while outN_valid=1 and outN_ready=0.
REQ-020 Pop = outN_valid && outN_ready; outN_ready while outN_valid=0 SHALL have no effect.
REQ-021 Push and pop same channel same edge: count unchanged, both pointers advance.
REQ-022 Push to one channel and pop of the other same edge SHALL both take effect.
REQ-023 Per-channel order SHALL be FIFO; no ordering between channels is implied.
REQ-024 Pointers SHALL wrap 1 -> 0; count SHALL never exceed 2 or underflow below 0.
REQ-025 outN_xfers SHALL increment by 1 on each pop of channel N, wrapping from 2^CNT_W-1 to 0.
REQ-026 in_valid with in_ready=0 SHALL not alter any state; the source holds the beat.
REQ-027 Changing sel while in_valid=1 and stalled SHALL be permitted; in_ready re-evaluates against the new channel.

Reset
REQ-028 rst_n=0 SHALL asynchronously clear all counts, pointers and xfer counters: outN_valid=0, outN_count=0, outN_xfers=0, in_ready=1.
REQ-029 FIFO storage need not be cleared; outN SHALL read 0 during reset and while outN_valid=0.
REQ-030 Reset mid-transfer SHALL discard all queued beats; a push coinciding with deassertion edge SHALL NOT be captured until the next edge.

Verification
REQ-031 Route: in=32'hAABBCCDD sel=0, then 32'h11223344 sel=1, both ready=1 -> out1=AABBCCDD, out2=11223344, each valid one cycle after accept; out1_xfers=out2_xfers=1.
REQ-032 Fill: out1_ready=0, push 32'h1, 32'h2 to sel=0 -> out1_count=2, in_ready=0 for sel=0, in_ready=1 for sel=1; third beat held, not lost.
REQ-033 Drain order: from full channel 1, out1_ready=1 -> out1 reads 1 then 2, count 2->1->0, out1_valid falls after second pop.
REQ-034 Simultaneous: channel 2 count=1, push sel=1 and pop out2 same edge -> out2_count stays 1, next head is new beat.
REQ-035 Reset mid-op: both channels count=2, pulse rst_n=0 between edges -> outputs clear immediately, in_ready=1, xfers=0, no stale beat after release.
REQ-036 Wrap: CNT_W=4, 17 pops on channel 1 -> out1_xfers=1.
